// File: rtl/memsync_row_mover.sv
// Row data mover for the MEMSync row cache: WriteBack copies a slot out to backing memory, Allocate fills a slot.
// Optional MEMSYNC_ROWMOVE_STATS_EN adds saturating 32-bit transfer counters wb_count / alloc_count.
module memsync_row_mover #(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 7,
  parameter int DWIDTH    = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wb_req,
  input  logic                          alloc_req,
  input  logic [CHWIDTH-1:0]            cRowId,
  input  logic [ADDRWIDTH-1:0]          RowId,
  input  logic [ADDRWIDTH-1:0]          vRowId,
  output logic                          sync,
  output logic [CHWIDTH+COLWIDTH-1:0]   c_addr,
  output logic                          c_rd_en,
  input  logic [DWIDTH-1:0]             c_rdata,
  output logic                          c_wr_en,
  output logic [DWIDTH-1:0]             c_wdata,
  output logic [ADDRWIDTH+COLWIDTH-1:0] m_addr,
  output logic                          m_cmd_valid,
  input  logic                          m_cmd_ready,
  output logic                          m_we,
  output logic [DWIDTH-1:0]             m_wdata,
  input  logic                          m_rvalid,
  input  logic [DWIDTH-1:0]             m_rdata
`ifdef MEMSYNC_ROWMOVE_STATS_EN
  ,
  output logic [31:0]                   wb_count,
  output logic [31:0]                   alloc_count
`endif
);

  typedef enum logic [2:0] {IDLE, WB_RD, WB_SEND, AL_CMD, AL_WAIT, DONE} state_t;

  localparam logic [COLWIDTH-1:0] COL_LAST = '1;

  state_t                 state, state_nxt;
  logic [CHWIDTH-1:0]     slot;
  logic [ADDRWIDTH-1:0]   row;
  logic [COLWIDTH-1:0]    col;
  logic [DWIDTH-1:0]      beat;
  logic                   beat_held;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot      <= '0;
      row       <= '0;
      col       <= '0;
      beat      <= '0;
      beat_held <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_held <= (state == WB_SEND) && !m_cmd_ready;
      case (state)
        IDLE: begin
          if (wb_req) begin
            slot <= cRowId;
            row  <= vRowId;
            col  <= '0;
          end else if (alloc_req) begin
            slot <= cRowId;
            row  <= RowId;
            col  <= '0;
          end
        end
        WB_SEND: begin
          // Cache data is only valid in the first WB_SEND cycle; keep it for a stalled command.
          if (!beat_held) beat <= c_rdata;
          if (m_cmd_ready && col != COL_LAST) col <= col + 1'b1;
        end
        AL_WAIT: begin
          if (m_rvalid && col != COL_LAST) col <= col + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    sync        = 1'b0;
    c_addr      = '0;
    c_rd_en     = 1'b0;
    c_wr_en     = 1'b0;
    c_wdata     = '0;
    m_addr      = '0;
    m_cmd_valid = 1'b0;
    m_we        = 1'b0;
    m_wdata     = '0;
    case (state)
      IDLE: begin
        if (wb_req)         state_nxt = WB_RD;
        else if (alloc_req) state_nxt = AL_CMD;
      end
      WB_RD: begin
        c_rd_en   = 1'b1;
        c_addr    = {slot, col};
        state_nxt = WB_SEND;
      end
      WB_SEND: begin
        m_cmd_valid = 1'b1;
        m_we        = 1'b1;
        m_addr      = {row, col};
        m_wdata     = beat_held ? beat : c_rdata;
        if (m_cmd_ready) state_nxt = (col == COL_LAST) ? DONE : WB_RD;
      end
      AL_CMD: begin
        m_cmd_valid = 1'b1;
        m_addr      = {row, col};
        if (m_cmd_ready) state_nxt = AL_WAIT;
      end
      AL_WAIT: begin
        if (m_rvalid) begin
          c_wr_en   = 1'b1;
          c_addr    = {slot, col};
          c_wdata   = m_rdata;
          state_nxt = (col == COL_LAST) ? DONE : AL_CMD;
        end
      end
      DONE: begin
        sync      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MEMSYNC_ROWMOVE_STATS_EN
  logic xfer_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_wb     <= 1'b0;
      wb_count    <= '0;
      alloc_count <= '0;
    end else begin
      if (state == IDLE) xfer_wb <= wb_req;
      if (state == DONE) begin
        if (xfer_wb && wb_count != '1)         wb_count    <= wb_count + 32'd1;
        if (!xfer_wb && alloc_count != '1)     alloc_count <= alloc_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_memsync_row_mover.sv
// Directed bench for memsync_row_mover with a 4-beat row, a behavioural cache and a backing memory with read latency 2.
module tb_memsync_row_mover;
  localparam int CHW = 6;
  localparam int AW  = 17;
  localparam int CW  = 2;
  localparam int DW  = 64;
  localparam int L   = 2;

  logic            clk = 1'b0;
  logic            rst, wb_req, alloc_req;
  logic [CHW-1:0]  cRowId;
  logic [AW-1:0]   RowId, vRowId;
  logic            sync, c_rd_en, c_wr_en, m_cmd_valid, m_cmd_ready, m_we, m_rvalid;
  logic [CHW+CW-1:0] c_addr;
  logic [AW+CW-1:0]  m_addr;
  logic [DW-1:0]   c_rdata = '0;
  logic [DW-1:0]   c_wdata, m_wdata, m_rdata;
`ifdef MEMSYNC_ROWMOVE_STATS_EN
  logic [31:0]     wb_count, alloc_count;
`endif

  memsync_row_mover #(.CHWIDTH(CHW), .ADDRWIDTH(AW), .COLWIDTH(CW), .DWIDTH(DW)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .alloc_req(alloc_req),
    .cRowId(cRowId), .RowId(RowId), .vRowId(vRowId), .sync(sync),
    .c_addr(c_addr), .c_rd_en(c_rd_en), .c_rdata(c_rdata), .c_wr_en(c_wr_en), .c_wdata(c_wdata),
    .m_addr(m_addr), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready), .m_we(m_we),
    .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
`ifdef MEMSYNC_ROWMOVE_STATS_EN
    , .wb_count(wb_count), .alloc_count(alloc_count)
`endif
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  int sync_cnt = 0;
  int both_strobe = 0;
  int ovl = 0;
  logic        rd_pend = 1'b0;
  int          rd_due = 0;
  logic [1:0]  rd_col = '0;
  logic [AW+CW-1:0]  bw_addr_q[$];
  logic [DW-1:0]     bw_data_q[$];
  logic [AW+CW-1:0]  rd_q[$];
  logic [CHW+CW-1:0] cw_addr_q[$];
  logic [DW-1:0]     cw_data_q[$];

  // Slot 5 holds 0x10+col; other slots 0x80+col. Outside a read response the bus carries junk.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (c_rd_en)
      c_rdata <= ((c_addr[CHW+CW-1:CW] == 6'd5) ? 64'h10 : 64'h80) + {62'd0, c_addr[1:0]};
    else
      c_rdata <= 64'hDEAD_BEEF_DEAD_BEEF;
    if (c_wr_en) begin
      cw_addr_q.push_back(c_addr);
      cw_data_q.push_back(c_wdata);
    end
    if (sync) sync_cnt <= sync_cnt + 1;
    if (c_rd_en && c_wr_en) both_strobe <= both_strobe + 1;
    if (rd_pend && cyc == rd_due) rd_pend <= 1'b0;
    if (m_cmd_valid && m_cmd_ready && m_we) begin
      bw_addr_q.push_back(m_addr);
      bw_data_q.push_back(m_wdata);
    end
    if (m_cmd_valid && !m_we && rd_pend && !(cyc == rd_due)) ovl <= ovl + 1;
    if (m_cmd_valid && m_cmd_ready && !m_we) begin
      rd_pend <= 1'b1;
      rd_due  <= cyc + L;
      rd_col  <= m_addr[1:0];
      rd_q.push_back(m_addr);
    end
  end

  assign m_rvalid = rd_pend && (cyc == rd_due);
  assign m_rdata  = m_rvalid ? (64'hA0 + {62'd0, rd_col}) : 64'h0BAD;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [191:0] all_out();
    return {32'd0, sync, c_rd_en, c_wr_en, m_cmd_valid, m_we, c_addr, m_addr, c_wdata, m_wdata};
  endfunction

  task automatic wait_sync(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sync) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Leave the DONE cycle and drop the request levels as MEMSync would.
  task automatic end_req();
    tick();
    wb_req    = 1'b0;
    alloc_req = 1'b0;
    check("sync_one_cycle", {191'd0, sync}, 192'd0);
  endtask

  task automatic clear_logs();
    bw_addr_q.delete(); bw_data_q.delete(); rd_q.delete();
    cw_addr_q.delete(); cw_data_q.delete();
  endtask

  int a, at, s, base_sync, base_cw;
  logic [AW+CW-1:0] hold_addr;
  logic [DW-1:0]    hold_data;
  logic             found;

  initial begin
    rst = 1'b1; wb_req = 1'b1; alloc_req = 1'b1;
    cRowId = '0; RowId = '0; vRowId = '0; m_cmd_ready = 1'b1;

    // Reset with requests held high
    tick();
    check("rst_outputs", all_out(), 192'd0);
    tick();
    check("rst_outputs2", all_out(), 192'd0);
    rst = 1'b0; wb_req = 1'b0; alloc_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", all_out(), 192'd0);
    end
`ifdef MEMSYNC_ROWMOVE_STATS_EN
    check("stats_rst", {128'd0, wb_count, alloc_count}, 192'd0);
`endif

    // WriteBack of slot 5 to row 0x1ABCD
    clear_logs();
    cRowId = 6'd5; vRowId = 17'h1ABCD; wb_req = 1'b1;
    a = cyc;
    wait_sync(60, at);
    check("wb_sync_cycle", at - a, 9);
    end_req();
    check("wb_writes", bw_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("wb_addr", bw_addr_q[i], 19'h6AF34 + 19'(i));
      check("wb_data", bw_data_q[i], 64'h10 + 64'(i));
    end

    // Allocate row 0x42 into slot 7
    clear_logs();
    cRowId = 6'd7; RowId = 17'h00042; alloc_req = 1'b1;
    a = cyc;
    wait_sync(80, at);
    check("al_sync_cycle", at - a, 13);
    end_req();
    check("al_reads", rd_q.size(), 4);
    check("al_cwrites", cw_addr_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check("al_rd_addr", rd_q[i], 19'h108 + 19'(i));
      check("al_c_addr", cw_addr_q[i], 8'h1C + 8'(i));
      check("al_c_data", cw_data_q[i], 64'hA0 + 64'(i));
    end
    check("al_one_outstanding", ovl, 0);

    // WriteBack with 5 stall cycles on beat 2
    clear_logs();
    cRowId = 6'd5; vRowId = 17'h00011; wb_req = 1'b1;
    a = cyc;
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (m_cmd_valid && m_we && m_addr[1:0] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    m_cmd_ready = 1'b0;
    check("bp_found_beat2", {191'd0, found}, 192'd1);
    check("bp_addr", m_addr, 19'h46);
    check("bp_data", m_wdata, 64'h12);
    hold_addr = m_addr; hold_data = m_wdata;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_stable", {m_cmd_valid, m_we, m_addr, m_wdata}, {2'b11, hold_addr, hold_data});
    end
    m_cmd_ready = 1'b1;
    wait_sync(60, at);
    check("bp_sync_cycle", at - a, 14);
    end_req();
    check("bp_writes", bw_addr_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check("bp_wdata", bw_data_q[i], 64'h10 + 64'(i));

    // WriteBack chained straight into an Allocate
    clear_logs();
    base_sync = sync_cnt;
    cRowId = 6'd5; vRowId = 17'h00033; wb_req = 1'b1;
    a = cyc;
    wait_sync(60, s);
    check("chain_wb_sync", s - a, 9);
    tick();
    wb_req = 1'b0; alloc_req = 1'b1; RowId = 17'h00042; cRowId = 6'd7;
    check("chain_gap_sync", {191'd0, sync}, 192'd0);
    tick();
    check("chain_al_start", {190'd0, m_cmd_valid, m_we}, 192'd2);
    wait_sync(80, at);
    check("chain_al_sync", at - (s + 1), 13);
    end_req();
    check("chain_pulses", sync_cnt - base_sync, 2);
`ifdef MEMSYNC_ROWMOVE_STATS_EN
    check("stats_counts", {128'd0, wb_count, alloc_count}, {128'd0, 32'd3, 32'd2});
`endif

    // Reset while waiting for backing read data
    base_sync = sync_cnt;
    base_cw = cw_addr_q.size();
    cRowId = 6'd7; RowId = 17'h00042; alloc_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_cmd_valid && !m_we) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_al_cmd_seen", {191'd0, found}, 192'd1);
    tick();
    check("mid_in_wait", {191'd0, m_cmd_valid}, 192'd0);
    rst = 1'b1; alloc_req = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_outputs", all_out(), 192'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_idle", all_out(), 192'd0);
    end
    check("mid_no_sync", sync_cnt - base_sync, 0);
    check("mid_no_cwrite", cw_addr_q.size() - base_cw, 0);
`ifdef MEMSYNC_ROWMOVE_STATS_EN
    check("stats_cleared", {128'd0, wb_count, alloc_count}, 192'd0);
`endif
    check("strobe_exclusive", both_strobe, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/memsync_row_mover.md
# memsync_row_mover

Data-movement engine paired with the `MEMSync` row-cache controller. `MEMSync` tracks which backing rows are resident in the chip-level row cache (`CHROWS` slots). It raises a WriteBack or Allocate request and waits for `sync`. This block moves the row data for that request:
- WriteBack: copies a victim slot out to backing memory.
- Allocate: copies the requested backing row into a slot.

It then pulses `sync` so `MEMSync` can leave its state.

## Interface
Parameters:
- `CHWIDTH`, 6, cache slot index width (`CHROWS = 2**CHWIDTH`)
- `ADDRWIDTH`, 17, backing row address width
- `COLWIDTH`, 7, beat index width; a row is `COLS = 2**COLWIDTH` beats
- `DWIDTH`, 64, beat data width

Ports:
- `clk` in 1: the single clock
- `rst` in 1: reset, synchronous and active-high
- `wb_req` in 1: level; high while `MEMSync` is in WriteBack
- `alloc_req` in 1: level; high while `MEMSync` is in Allocate
- `cRowId` in `CHWIDTH`: cache slot being evicted or filled
- `RowId` in `ADDRWIDTH`: backing row to fetch (Allocate)
- `vRowId` in `ADDRWIDTH`: backing row of the victim (WriteBack)
- `sync` out 1: one-cycle done pulse to `MEMSync`
- `c_addr` out `CHWIDTH+COLWIDTH`: cache address, `{slot, col}`
- `c_rd_en` out 1: cache read strobe; data arrives on `c_rdata` the next cycle
- `c_rdata` in `DWIDTH`: cache read data
- `c_wr_en` out 1: cache write strobe
- `c_wdata` out `DWIDTH`: cache write data
- `m_addr` out `ADDRWIDTH+COLWIDTH`: backing address, `{row, col}`
- `m_cmd_valid` out 1: backing command valid
- `m_cmd_ready` in 1: backing command accepted
- `m_we` out 1: command is a write (1) or a read (0)
- `m_wdata` out `DWIDTH`: backing write data
- `m_rvalid` in 1: backing read data valid
- `m_rdata` in `DWIDTH`: backing read data

## Operation
States:
- `IDLE`
- `WB_RD`
- `WB_SEND`
- `AL_CMD`
- `AL_WAIT`
- `DONE`

Transitions and actions:
- **IDLE.** Samples requests every cycle.
  - `wb_req` → `WB_RD`; `alloc_req` → `AL_CMD`. `wb_req` wins if both are high.
  - On entry to a request, latches `cRowId` and the row (`vRowId` for WriteBack, `RowId` for Allocate). Sets `col=0`.
  - Request inputs are ignored outside `IDLE`.
- **WB_RD.**
  - Drives `c_rd_en=1` and `c_addr={slot,col}` for one cycle.
  - Next cycle: goes to `WB_SEND`, captures `c_rdata` into the beat register.
- **WB_SEND.**
  - Drives `m_cmd_valid=1`, `m_we=1`, `m_addr={row,col}`, `m_wdata`=beat register.
  - Holds all of them stable until `m_cmd_ready`.
  - On handshake: if `col==COLS-1` → `DONE`; else `col+1` → `WB_RD`.
- **AL_CMD.**
  - Drives `m_cmd_valid=1`, `m_we=0`, `m_addr={row,col}` until `m_cmd_ready`.
  - On handshake → `AL_WAIT`.
- **AL_WAIT.**
  - Waits for `m_rvalid`.
  - In the `m_rvalid` cycle, drives `c_wr_en=1`, `c_addr={slot,col}`, `c_wdata=m_rdata` (combinational).
  - Then: if `col==COLS-1` → `DONE`; else `col+1` → `AL_CMD`.
  - At most one backing read is outstanding.
- **DONE.** Drives `sync=1` for exactly one cycle, then → `IDLE`.
- **Handover.** `MEMSync` samples `sync` on the same edge this block leaves `DONE`. The request levels seen in the following `IDLE` cycle therefore already reflect `MEMSync`'s new state. A WriteBack→Allocate chain starts back-to-back with no guard cycle.
- **Column counter.** `COLWIDTH` bits. Wrap-around from `COLS-1` is never used; the terminal test precedes the increment.
- **`m_rvalid` outside `AL_WAIT`.** Ignored. This is a protocol error and is not flagged.

## Timing
- **Reset values:** all outputs 0 (`sync`, `c_rd_en`, `c_wr_en`, `m_cmd_valid`, `m_we`, addresses, data).
- **Reset state and reset mid-transfer:** state `IDLE`, `col=0`.
  - A reset mid-transfer abandons the row.
  - `sync` is not pulsed.
- **WriteBack latency,** with `m_cmd_ready` always high:
  - 2 cycles per beat.
  - `sync` is high in cycle `2*COLS+1` after the `IDLE` cycle that accepted `wb_req`.
- **Allocate latency,** with `m_cmd_ready` high and `m_rvalid` L cycles after the handshake:
  - `(1+L)` cycles per beat.
  - `sync` is high in cycle `COLS*(1+L)+1` after acceptance.
- **Stalls:** backpressure on `m_cmd_ready` stretches `WB_SEND` or `AL_CMD` indefinitely with outputs held. No timeout.
- **Strobes:** `c_rd_en` and `c_wr_en` are never high in the same cycle.

## Configuration
- **`MEMSYNC_ROWMOVE_STATS_EN` defined:**
  - Adds outputs `wb_count` and `alloc_count`, 32 bits each.
  - Each increments in the `DONE` cycle of its transfer type.
  - Both saturate at `2**32-1` and are cleared by `rst`.
- **Not defined:** those ports and counters do not exist. All other behaviour is identical.

## Test plan
Bench configuration: `COLWIDTH=2` (4 beats), `DWIDTH=64`.
- **Reset.** Assert `rst` 2 cycles, with requests high → all outputs 0, state `IDLE`, no `sync` for 3 cycles after release with requests low.
- **WriteBack, no backpressure.** `wb_req=1`, `cRowId=5`, `vRowId=0x1ABCD`; cache slot 5 holds `0x10..0x13` → four backing writes to addresses `{0x1ABCD,0..3}` with data `0x10..0x13`; `sync` high exactly cycle 9.
- **Allocate, L=2.** `alloc_req=1`, `RowId=0x00042`, `cRowId=7`; backing returns `0xA0..0xA3` → cache writes to `{7,0..3}`; `sync` at cycle 13; one outstanding read at a time.
- **Backpressure.** `m_cmd_ready` low 5 cycles on beat 2 of a WriteBack → `m_addr`/`m_wdata` stable throughout; `sync` delayed by exactly 5 cycles.
- **Chain.** `wb_req` drops and `alloc_req` rises on the edge after `sync` → Allocate starts the next cycle; two `sync` pulses total.
- **Mid-transfer reset and stats.** Reset asserted in `AL_WAIT` → `IDLE`, no `sync`. With `MEMSYNC_ROWMOVE_STATS_EN`, after 3 WriteBacks and 2 Allocates the counters read 3 and 2; reset clears both to 0.
